// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if -- instruction-memory fetch bus.
//   imem_req   : fetch request, driven by the fetch unit
//   imem_addr  : fetch address, driven by the fetch unit
//   imem_ready : imem_rdata is valid this cycle, driven by memory
//   imem_rdata : fetched instruction word, driven by memory
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ready, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- two-state (FETCH/ISSUE) program counter and fetch unit.
// Fetches one word at the current PC, holds it for downstream until it is
// accepted (ISSUE and !stall), then steps the PC by priority
// jr > jump > branch > sequential.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   stall                  : downstream cannot take the presented instruction
//   branch_taken/sign_ext_imm, jump/jump_target, jr/jr_addr : redirects
//   imem (master)          : fetch bus to instruction memory
//   instr, instr_valid     : presented instruction
//   imm                    : instr[15:0]
//   pc, pc_plus4           : address of presented instruction and pc+4
//   pc_misalign            : one-cycle pulse after a jr with jr_addr[1:0]!=0
//   fetch_count            : accepted-instruction count (wraps)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [31:0]            sign_ext_imm,
    input  logic                   jump,
    input  logic [25:0]            jump_target,
    input  logic                   jr,
    input  logic [31:0]            jr_addr,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [15:0]            imm,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   pc_misalign,
    output logic [31:0]            fetch_count
);

    typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misalign_q, misalign_d;

    logic        accept;
    logic [31:0] redirect_pc;

    // Shifting the word offset left by two drops its top two bits.
    logic unused_imm_hi;
    assign unused_imm_hi = ^sign_ext_imm[31:30];

    assign accept   = (state_q == ISSUE) && !stall;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        redirect_pc = pc_plus4;
        if (jr)
            redirect_pc = {jr_addr[31:2], 2'b00};
        else if (jump)
            redirect_pc = {pc_plus4[31:28], jump_target, 2'b00};
        else if (branch_taken)
            redirect_pc = pc_plus4 + {sign_ext_imm[29:0], 2'b00};
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Redirect inputs only matter in the accept cycle.
                if (accept) begin
                    pc_d          = redirect_pc;
                    fetch_count_d = fetch_count_q + 32'd1;
                    misalign_d    = jr && (jr_addr[1:0] != 2'b00);
                    state_d       = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'd0;
            fetch_count_q <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    // Handshake outputs are squashed while reset is held.
    assign imem.imem_req  = (state_q == FETCH) && !reset;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ISSUE) && !reset;
    assign instr          = instr_q;
    assign imm            = instr_q[15:0];
    assign pc             = pc_q;
    assign pc_misalign    = misalign_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit. Each record gives the
// inputs for one clock cycle and the state expected just after that edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jr;
    logic [31:0] sign_ext_imm, jr_addr;
    logic [25:0] jump_target;
    logic [31:0] instr, pc, pc_plus4, fetch_count;
    logic        instr_valid, pc_misalign;
    logic [15:0] imm;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .sign_ext_imm(sign_ext_imm),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr),
        .imem(bus.master),
        .instr(instr), .instr_valid(instr_valid), .imm(imm),
        .pc(pc), .pc_plus4(pc_plus4), .pc_misalign(pc_misalign),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ready;
        logic [31:0] rdata;
        logic        stl;
        logic        br;
        logic [31:0] sxi;
        logic        jmp;
        logic [25:0] jt;
        logic        jrr;
        logic [31:0] jra;
        logic        e_req;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    function automatic vec_t v(logic ready, logic [31:0] rdata, logic stl,
                               logic br, logic [31:0] sxi, logic jmp,
                               logic [25:0] jt, logic jrr, logic [31:0] jra,
                               logic e_req, logic e_vld, logic [31:0] e_pc,
                               logic [31:0] e_instr, logic [31:0] e_cnt,
                               logic e_mis);
        vec_t r;
        r.rst = 1'b0; r.ready = ready; r.rdata = rdata; r.stl = stl;
        r.br = br; r.sxi = sxi; r.jmp = jmp; r.jt = jt; r.jrr = jrr;
        r.jra = jra; r.e_req = e_req; r.e_vld = e_vld; r.e_pc = e_pc;
        r.e_instr = e_instr; r.e_cnt = e_cnt; r.e_mis = e_mis;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(string tag, vec_t x);
        logic [31:0] e_p4;
        e_p4 = x.e_pc + 32'd4;
        check({tag, " imem_req"},    {31'd0, bus.imem_req}, {31'd0, x.e_req});
        check({tag, " instr_valid"}, {31'd0, instr_valid},  {31'd0, x.e_vld});
        check({tag, " pc"},          pc,                    x.e_pc);
        check({tag, " imem_addr"},   bus.imem_addr,         x.e_pc);
        check({tag, " pc_plus4"},    pc_plus4,              e_p4);
        check({tag, " instr"},       instr,                 x.e_instr);
        check({tag, " imm"},         {16'd0, imm},          {16'd0, x.e_instr[15:0]});
        check({tag, " fetch_count"}, fetch_count,           x.e_cnt);
        check({tag, " pc_misalign"}, {31'd0, pc_misalign},  {31'd0, x.e_mis});
    endtask

    // Drive one cycle of inputs, clock once, and check 1 ns after the edge.
    task automatic run_vec(string tag, vec_t x);
        reset          = x.rst;
        bus.imem_ready = x.ready;
        bus.imem_rdata = x.rdata;
        stall          = x.stl;
        branch_taken   = x.br;
        sign_ext_imm   = x.sxi;
        jump           = x.jmp;
        jump_target    = x.jt;
        jr             = x.jrr;
        jr_addr        = x.jra;
        @(posedge clk);
        #1;
        check_state(tag, x);
    endtask

    localparam logic [25:0] JT0 = 26'd0;

    vec_t tbl[24];
    vec_t h;

    initial begin
        // cycle | ready rdata      stl br sxi           jmp jt           jr jra            | req vld pc            instr         cnt mis
        tbl[0]  = v(1, 32'hA000_0000, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h0,         32'hA000_0000, 0, 0);
        tbl[1]  = v(0, 32'h0,         0, 0, 32'd0,        0, JT0,          0, 32'd0,          1, 0, 32'h4,         32'hA000_0000, 1, 0);
        tbl[2]  = v(0, 32'hBAD0_BAD0, 0, 1, 32'd16,       1, 26'd5,        1, 32'h40,         1, 0, 32'h4,         32'hA000_0000, 1, 0);
        tbl[3]  = v(1, 32'hA000_0001, 0, 1, 32'd16,       1, 26'd5,        1, 32'h40,         0, 1, 32'h4,         32'hA000_0001, 1, 0);
        tbl[4]  = v(0, 32'h0,         0, 0, 32'd0,        0, JT0,          0, 32'd0,          1, 0, 32'h8,         32'hA000_0001, 2, 0);
        tbl[5]  = v(1, 32'hA000_0002, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h8,         32'hA000_0002, 2, 0);
        tbl[6]  = v(1, 32'hDEAD_0000, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          1, 0, 32'hC,         32'hA000_0002, 3, 0);
        tbl[7]  = v(1, 32'hA000_0003, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'hC,         32'hA000_0003, 3, 0);
        tbl[8]  = v(0, 32'h0,         0, 0, 32'd0,        0, JT0,          0, 32'd0,          1, 0, 32'h10,        32'hA000_0003, 4, 0);
        tbl[9]  = v(1, 32'h1234_8001, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h10,        32'h1234_8001, 4, 0);
        tbl[10] = v(0, 32'h0,         0, 1, 32'hFFFF_FFFE,0, JT0,          0, 32'd0,          1, 0, 32'hC,         32'h1234_8001, 5, 0);
        tbl[11] = v(1, 32'hA000_0005, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'hC,         32'hA000_0005, 5, 0);
        tbl[12] = v(0, 32'h0,         0, 1, 32'd8,        1, 26'h3FF_FFFF, 1, 32'h0000_0102,  1, 0, 32'h100,       32'hA000_0005, 6, 1);
        tbl[13] = v(0, 32'h0,         0, 0, 32'd0,        0, JT0,          0, 32'd0,          1, 0, 32'h100,       32'hA000_0005, 6, 0);
        tbl[14] = v(1, 32'hA000_0006, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h100,       32'hA000_0006, 6, 0);
        tbl[15] = v(0, 32'h0,         0, 1, 32'd8,        1, 26'h3FF_FFFF, 0, 32'd0,          1, 0, 32'h0FFF_FFFC, 32'hA000_0006, 7, 0);
        tbl[16] = v(1, 32'hA000_0007, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h0FFF_FFFC, 32'hA000_0007, 7, 0);
        tbl[17] = v(0, 32'h0,         0, 0, 32'd0,        1, 26'h10,       0, 32'd0,          1, 0, 32'h1000_0040, 32'hA000_0007, 8, 0);
        tbl[18] = v(1, 32'hA000_0008, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h1000_0040, 32'hA000_0008, 8, 0);
        tbl[19] = v(0, 32'h0,         0, 1, 32'd3,        0, JT0,          0, 32'd0,          1, 0, 32'h1000_0050, 32'hA000_0008, 9, 0);
        tbl[20] = v(1, 32'hA000_0009, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'h1000_0050, 32'hA000_0009, 9, 0);
        tbl[21] = v(0, 32'h0,         0, 0, 32'd0,        0, JT0,          1, 32'hFFFF_FFFC,  1, 0, 32'hFFFF_FFFC, 32'hA000_0009, 10, 0);
        tbl[22] = v(1, 32'hA000_000A, 0, 0, 32'd0,        0, JT0,          0, 32'd0,          0, 1, 32'hFFFF_FFFC, 32'hA000_000A, 10, 0);
        tbl[23] = v(0, 32'h0,         0, 0, 32'd0,        0, JT0,          0, 32'd0,          1, 0, 32'h0,         32'hA000_000A, 11, 0);

        // Reset with memory offering data: reset must win.
        h = v(1, 32'h5555_5555, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 0, 0, 32'h0, 32'h0, 0, 0);
        h.rst = 1'b1;
        run_vec("reset0", h);
        run_vec("reset1", h);

        for (int i = 0; i < 24; i++)
            run_vec($sformatf("vec%0d", i), tbl[i]);

        // Stall for three ISSUE cycles with branch_taken toggling, release
        // with branch_taken=0: sequential step only.
        run_vec("stlA_fetch", v(1, 32'hB000_0000, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 0, 1, 32'h0, 32'hB000_0000, 11, 0));
        run_vec("stlA_s0",    v(0, 32'h0, 1, 1, 32'd4, 0, JT0, 0, 32'd0, 0, 1, 32'h0, 32'hB000_0000, 11, 0));
        run_vec("stlA_s1",    v(1, 32'hEEEE_EEEE, 1, 0, 32'd4, 1, JT0, 1, 32'h8, 0, 1, 32'h0, 32'hB000_0000, 11, 0));
        run_vec("stlA_s2",    v(0, 32'h0, 1, 1, 32'd4, 0, JT0, 0, 32'd0, 0, 1, 32'h0, 32'hB000_0000, 11, 0));
        run_vec("stlA_rel",   v(0, 32'h0, 0, 0, 32'd4, 0, JT0, 0, 32'd0, 1, 0, 32'h4, 32'hB000_0000, 12, 0));

        // Same again, but branch_taken=1 in the release cycle: 8 + 4*4 = 0x18.
        run_vec("stlB_fetch", v(1, 32'hB000_0001, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 0, 1, 32'h4, 32'hB000_0001, 12, 0));
        run_vec("stlB_s0",    v(0, 32'h0, 1, 1, 32'd4, 0, JT0, 0, 32'd0, 0, 1, 32'h4, 32'hB000_0001, 12, 0));
        run_vec("stlB_s1",    v(0, 32'h0, 1, 0, 32'd4, 0, JT0, 0, 32'd0, 0, 1, 32'h4, 32'hB000_0001, 12, 0));
        run_vec("stlB_rel",   v(0, 32'h0, 0, 1, 32'd4, 0, JT0, 0, 32'd0, 1, 0, 32'h18, 32'hB000_0001, 13, 0));

        // fetch_count wrap: preload the counter while in FETCH, then accept once.
        @(negedge clk);
        dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        check("wrap_preload", fetch_count, 32'hFFFF_FFFF);
        run_vec("wrap_fetch", v(1, 32'hB000_0002, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 0, 1, 32'h18, 32'hB000_0002, 32'hFFFF_FFFF, 0));
        run_vec("wrap_acc",   v(0, 32'h0, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 1, 0, 32'h1C, 32'hB000_0002, 0, 0));

        // Reset in FETCH with imem_ready=1.
        h = v(1, 32'hDEAD_BEEF, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 0, 0, 32'h0, 32'h0, 0, 0);
        h.rst = 1'b1;
        run_vec("rstF", h);
        run_vec("rstF_rel", v(0, 32'h0, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 1, 0, 32'h0, 32'h0, 0, 0));

        // Reset during an accept carrying a misaligned jr: reset wins.
        run_vec("rstI_fetch", v(1, 32'hC000_0000, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 0, 1, 32'h0, 32'hC000_0000, 0, 0));
        h = v(0, 32'h0, 0, 1, 32'd4, 1, 26'd7, 1, 32'h0000_0203, 0, 0, 32'h0, 32'h0, 0, 0);
        h.rst = 1'b1;
        run_vec("rstI", h);
        run_vec("rstI_rel", v(0, 32'h0, 0, 0, 32'd0, 0, JT0, 0, 32'd0, 1, 0, 32'h0, 32'h0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  downstream cannot accept the presented instruction.
REQ-005 SHALL have port: branch_taken  input  1  take the PC-relative branch on accept.
REQ-006 SHALL have port: sign_ext_imm  input  32  sign-extended branch offset, in words.
REQ-007 SHALL have port: jump  input  1  take the absolute J-type jump on accept.
REQ-008 SHALL have port: jump_target  input  26  J-type target field.
REQ-009 SHALL have port: jr  input  1  take the register jump on accept.
REQ-010 SHALL have port: jr_addr  input  32  register jump address.
REQ-011 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-012 SHALL have port: imem_addr  output  32  fetch address (always the current PC).
REQ-013 SHALL have port: imem_ready  input  1  imem_rdata valid this cycle.
REQ-014 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-015 SHALL have port: instr  output  32  held instruction word.
REQ-016 SHALL have port: instr_valid  output  1  instr is presented downstream.
REQ-017 SHALL have port: imm  output  16  instr[15:0], feeding the sign extender.
REQ-018 SHALL have port: pc  output  32  address of the presented instruction.
REQ-019 SHALL have port: pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-020 SHALL have port: pc_misalign  output  1  one-cycle pulse when jr_addr[1:0] is nonzero on an accepted jr.
REQ-021 SHALL have port: fetch_count  output  32  count of accepted instructions.

Function
REQ-022 SHALL implement two states, FETCH and ISSUE.
REQ-023 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-024 In FETCH with imem_ready=1, the block SHALL capture imem_rdata into instr and move to ISSUE at that edge.
REQ-025 In FETCH with imem_ready=0, the block SHALL remain in FETCH with pc unchanged.
REQ-026 In ISSUE, instr_valid SHALL be 1 and imem_req SHALL be 0.
REQ-027 Accept is defined as ISSUE and stall=0; only on accept SHALL the pc update, fetch_count increment (wrapping at 2^32) and the state return to FETCH.
REQ-028 In ISSUE with stall=1, instr, pc and fetch_count SHALL hold, and redirect inputs SHALL be ignored.
REQ-029 The next PC on accept SHALL be chosen by priority jr > jump > branch_taken > sequential.
- jr: {jr_addr[31:2], 2'b00}; pc_misalign SHALL pulse for 1 cycle if jr_addr[1:0] != 0.
- jump: {pc_plus4[31:28], jump_target, 2'b00}.
- branch: pc_plus4 + (sign_ext_imm << 2), truncated to 32 bits.
- sequential: pc_plus4.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles (imem_ready=1 in FETCH, stall=0 in ISSUE).
REQ-031 PC arithmetic SHALL wrap: pc=32'hFFFF_FFFC sequential SHALL give 32'h0000_0000.
REQ-032 imm SHALL always equal instr[15:0], and pc_plus4 SHALL always equal pc+4 (combinational).
REQ-033 Redirect inputs SHALL be sampled only in the accept cycle; their values in FETCH SHALL have no effect.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL set state=FETCH, pc=RESET_VECTOR, instr=0, fetch_count=0 and pc_misalign=0, overriding any simultaneous imem_ready or accept.
REQ-035 While reset=1, imem_req and instr_valid SHALL be forced to 0.

Verification
REQ-036 Reset, then imem_ready=1 and stall=0 held -> imem_addr SHALL be 0, 4, 8, ... on alternate cycles, instr_valid SHALL toggle, and fetch_count SHALL increment once per accept.
REQ-037 With pc=32'h10, sign_ext_imm=32'hFFFF_FFFE and branch_taken=1 on accept -> next imem_addr SHALL be 32'h0C.
REQ-038 With jr=1 (jr_addr=32'h0000_0102), jump=1 and branch_taken=1 on the same accept -> next pc SHALL be 32'h100 and pc_misalign SHALL pulse for 1 cycle.
REQ-039 With stall=1 for 3 ISSUE cycles, during which branch_taken toggles -> instr, pc and fetch_count SHALL be stable and no imem_req SHALL occur; the branch SHALL apply only if branch_taken=1 in the release cycle.
REQ-040 With reset=1 in the same cycle as imem_ready=1 in FETCH -> pc SHALL be RESET_VECTOR, instr SHALL be 0 and instr_valid SHALL be 0 the next cycle.
REQ-041 With pc=32'hFFFF_FFFC and a sequential accept -> pc SHALL be 32'h0; with fetch_count preloaded to 32'hFFFF_FFFF via a forced sequence, fetch_count SHALL wrap to 0.
